// File: rtl/encoder_ctrl_if.sv
// ---------------------------------------------------------------------------
// encoder_ctrl_if
// Groups every non-clock/reset signal of encoder_ctrl into one bundle.
//   Host handshake : IN_IMAGE, IN_VALID, IN_READY, ABORT
//   Encoder drive  : IMAGE, NEW_IMAGE
//   Encoder status : IMAGE_ENCODED, AEROUT_REQ, AEROUT_ACK (monitored only)
//   Host status    : BUSY, DONE, TIMEOUT_ERR, SPIKE_COUNT, IMG_COUNT
// Modports:
//   master : host/encoder side, drives the controller's inputs
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface encoder_ctrl_if #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
);
  logic [0:IMAGE_SIZE-1][PIXEL_BITS:0] IN_IMAGE;
  logic                                IN_VALID;
  logic                                IN_READY;
  logic                                ABORT;
  logic [0:IMAGE_SIZE-1][PIXEL_BITS:0] IMAGE;
  logic                                NEW_IMAGE;
  logic                                IMAGE_ENCODED;
  logic                                AEROUT_REQ;
  logic                                AEROUT_ACK;
  logic                                BUSY;
  logic                                DONE;
  logic                                TIMEOUT_ERR;
  logic [IMAGE_SIZE_BITS:0]            SPIKE_COUNT;
  logic [15:0]                         IMG_COUNT;

  modport master (
    output IN_IMAGE, IN_VALID, ABORT, IMAGE_ENCODED, AEROUT_REQ, AEROUT_ACK,
    input  IN_READY, IMAGE, NEW_IMAGE, BUSY, DONE, TIMEOUT_ERR, SPIKE_COUNT,
           IMG_COUNT
  );

  modport slave (
    input  IN_IMAGE, IN_VALID, ABORT, IMAGE_ENCODED, AEROUT_REQ, AEROUT_ACK,
    output IN_READY, IMAGE, NEW_IMAGE, BUSY, DONE, TIMEOUT_ERR, SPIKE_COUNT,
           IMG_COUNT
  );
endinterface

// File: rtl/encoder_ctrl.sv
// ---------------------------------------------------------------------------
// encoder_ctrl
// Frame-level controller feeding images to the spike encoder. Accepts one
// image from the host, holds it on IMAGE, pulses NEW_IMAGE, waits for the
// encoder to finish and the AER link to fall idle, then rests for
// REST_CYCLES before accepting the next image. A watchdog bounds ENCODE.
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous active-high reset
//   bus : encoder_ctrl_if.slave (host handshake, encoder drive, AER monitor,
//         status/counters)
// ---------------------------------------------------------------------------
module encoder_ctrl #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int REST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic           CLK,
  input logic           RST,
  encoder_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENCODE,
    S_DRAIN,
    S_REST
  } state_t;

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REST_W = (REST_CYCLES > 0) ? $clog2(REST_CYCLES + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REST_W-1:0] REST_LAST =
    REST_W'((REST_CYCLES > 0) ? REST_CYCLES - 1 : 0);
  localparam logic [IMAGE_SIZE_BITS:0] SPIKE_MAX = '1;
  // With a zero rest gap the REST state is skipped entirely.
  localparam state_t AFTER_RUN = (REST_CYCLES == 0) ? S_IDLE : S_REST;

  state_t                              r_state;
  state_t                              w_next;
  logic [WDOG_W-1:0]                   r_wdog;
  logic [REST_W-1:0]                   r_rest;
  logic [0:IMAGE_SIZE-1][PIXEL_BITS:0] r_image;
  logic [IMAGE_SIZE_BITS:0]            r_spikeCount;
  logic [15:0]                         r_imgCount;
  logic                                r_timeoutErr;
  logic                                r_reqQ;
  logic                                r_ackQ;
  logic                                w_accept;
  logic                                w_linkIdle;
  logic                                w_reqRise;
  logic                                w_counting;
  logic                                w_timeoutHit;
  logic                                w_imageDone;

  assign w_accept   = (r_state == S_IDLE) && bus.IN_VALID;
  // The link is judged on the registered REQ/ACK, so DONE and the DRAIN exit
  // depend only on flops and DONE lines up with the cycle that leaves DRAIN.
  assign w_linkIdle = !r_reqQ && !r_ackQ;
  assign w_reqRise  = bus.AEROUT_REQ && !r_reqQ;
  assign w_counting = (r_state == S_LOAD) || (r_state == S_ENCODE) ||
                      (r_state == S_DRAIN);

  // State register; reset and ABORT both land in IDLE.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. ABORT outranks everything outside IDLE, then the
  // watchdog, then IMAGE_ENCODED. The two strobes mark the cycles where an
  // image ends by timeout or by normal completion.
  always_comb begin
    w_next       = r_state;
    w_timeoutHit = 1'b0;
    w_imageDone  = 1'b0;
    if ((r_state != S_IDLE) && bus.ABORT) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.IN_VALID) w_next = S_LOAD;
        S_LOAD:   w_next = S_ENCODE;
        S_ENCODE: begin
          if (r_wdog == WDOG_LAST) begin
            w_next       = AFTER_RUN;
            w_timeoutHit = 1'b1;
          end else if (bus.IMAGE_ENCODED) begin
            w_next = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_linkIdle) begin
            w_next      = AFTER_RUN;
            w_imageDone = 1'b1;
          end
        end
        S_REST:   if (r_rest == REST_LAST) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Watchdog and rest counters sit at zero outside their own state, which
  // gives the clear-on-entry behaviour for free.
  always_ff @(posedge CLK) begin
    if (RST || (r_state != S_ENCODE)) r_wdog <= '0;
    else                              r_wdog <= r_wdog + WDOG_W'(1);
    if (RST || (r_state != S_REST))   r_rest <= '0;
    else                              r_rest <= r_rest + REST_W'(1);
  end

  // Image latch and spike counter. IMAGE only moves on an accepted
  // handshake; the spike count restarts there and otherwise saturates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_image      <= '0;
      r_spikeCount <= '0;
    end else if (w_accept) begin
      r_image      <= bus.IN_IMAGE;
      r_spikeCount <= '0;
    end else if (w_counting && w_reqRise && (r_spikeCount != SPIKE_MAX)) begin
      r_spikeCount <= r_spikeCount + (IMAGE_SIZE_BITS + 1)'(1);
    end
  end

  // Host-visible status: completed-image count, sticky watchdog flag, and
  // the AER samples used for edge detection and the drain check.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_imgCount   <= '0;
      r_timeoutErr <= 1'b0;
      r_reqQ       <= 1'b0;
      r_ackQ       <= 1'b0;
    end else begin
      if (w_imageDone)  r_imgCount   <= r_imgCount + 16'd1;
      if (w_timeoutHit) r_timeoutErr <= 1'b1;
      r_reqQ <= bus.AEROUT_REQ;
      r_ackQ <= bus.AEROUT_ACK;
    end
  end

  assign bus.IN_READY    = (r_state == S_IDLE);
  assign bus.NEW_IMAGE   = (r_state == S_LOAD);
  assign bus.BUSY        = (r_state != S_IDLE);
  assign bus.DONE        = (r_state == S_DRAIN) && w_linkIdle;
  assign bus.IMAGE       = r_image;
  assign bus.TIMEOUT_ERR = r_timeoutErr;
  assign bus.SPIKE_COUNT = r_spikeCount;
  assign bus.IMG_COUNT   = r_imgCount;

endmodule

// File: tb/tb_encoder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_encoder_ctrl
// Directed bench for encoder_ctrl. Two instances share one stimulus set:
//   dutA : REST_CYCLES=16, TIMEOUT_CYCLES=1024 (normal, drain, abort, sat.)
//   dutB : REST_CYCLES=0,  TIMEOUT_CYCLES=8    (watchdog, back-to-back)
// 'sel' routes the stimulus to one instance; the other sees idle inputs.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_encoder_ctrl;

  typedef logic [0:4][4:0] img_t;

  logic       clk = 1'b0;
  logic       tbRst;
  logic       sel;
  img_t       tbImage;
  logic       tbValid, tbAbort, tbEncoded, tbReq, tbAck;
  int         vectors = 0;
  int         miscompares = 0;
  int         doneA = 0;
  int         doneB = 0;

  logic       obsReady, obsNew, obsBusy, obsDone, obsTerr;
  logic [3:0] obsSpike;
  logic [15:0] obsImg;
  img_t       obsImage;

  always #5 clk = ~clk;

  encoder_ctrl_if #(.IMAGE_SIZE(5), .PIXEL_MAX_VALUE(10)) ifA ();
  encoder_ctrl_if #(.IMAGE_SIZE(5), .PIXEL_MAX_VALUE(10)) ifB ();

  encoder_ctrl #(.IMAGE_SIZE(5), .PIXEL_MAX_VALUE(10), .REST_CYCLES(16),
                 .TIMEOUT_CYCLES(1024))
    dutA (.CLK(clk), .RST(tbRst), .bus(ifA));

  encoder_ctrl #(.IMAGE_SIZE(5), .PIXEL_MAX_VALUE(10), .REST_CYCLES(0),
                 .TIMEOUT_CYCLES(8))
    dutB (.CLK(clk), .RST(tbRst), .bus(ifB));

  // Stimulus routing: only the selected instance sees the driven inputs.
  assign ifA.IN_IMAGE      = sel ? '0   : tbImage;
  assign ifA.IN_VALID      = sel ? 1'b0 : tbValid;
  assign ifA.ABORT         = sel ? 1'b0 : tbAbort;
  assign ifA.IMAGE_ENCODED = sel ? 1'b0 : tbEncoded;
  assign ifA.AEROUT_REQ    = sel ? 1'b0 : tbReq;
  assign ifA.AEROUT_ACK    = sel ? 1'b0 : tbAck;
  assign ifB.IN_IMAGE      = sel ? tbImage   : '0;
  assign ifB.IN_VALID      = sel ? tbValid   : 1'b0;
  assign ifB.ABORT         = sel ? tbAbort   : 1'b0;
  assign ifB.IMAGE_ENCODED = sel ? tbEncoded : 1'b0;
  assign ifB.AEROUT_REQ    = sel ? tbReq     : 1'b0;
  assign ifB.AEROUT_ACK    = sel ? tbAck     : 1'b0;

  // Observation of the selected instance.
  assign obsReady = sel ? ifB.IN_READY    : ifA.IN_READY;
  assign obsNew   = sel ? ifB.NEW_IMAGE   : ifA.NEW_IMAGE;
  assign obsBusy  = sel ? ifB.BUSY        : ifA.BUSY;
  assign obsDone  = sel ? ifB.DONE        : ifA.DONE;
  assign obsTerr  = sel ? ifB.TIMEOUT_ERR : ifA.TIMEOUT_ERR;
  assign obsSpike = sel ? ifB.SPIKE_COUNT : ifA.SPIKE_COUNT;
  assign obsImg   = sel ? ifB.IMG_COUNT   : ifA.IMG_COUNT;
  assign obsImage = sel ? ifB.IMAGE       : ifA.IMAGE;

  // Count DONE cycles per instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifA.DONE === 1'b1) doneA++;
    if (ifB.DONE === 1'b1) doneB++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One four-phase AER handshake, ACK answering REQ after ackDelay cycles.
  task automatic spike(input int ackDelay);
    tbReq = 1'b1;
    repeat (ackDelay) tick();
    tbAck = 1'b1;
    tick();
    tbReq = 1'b0;
    tick();
    tbAck = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    img_t pat;
    pat = {5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    vectors++; if (obsReady !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ready: got %0b expected 1", obsReady); end
    vectors++; if (obsBusy !== 1'b0 || obsNew !== 1'b0 || obsDone !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_flags: busy=%0b new=%0b done=%0b expected 0/0/0", obsBusy, obsNew, obsDone); end
    vectors++; if (obsSpike !== 4'd0 || obsImg !== 16'd0 || obsTerr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_counts: spike=%0d img=%0d terr=%0b expected 0/0/0", obsSpike, obsImg, obsTerr); end
    vectors++; if (obsImage !== '0) begin miscompares++; $display("[TB] FAIL rst_image: got %h expected 0", obsImage); end
    tbImage = pat; tbValid = 1'b1;
    tick();
    tbValid = 1'b0;
    vectors++; if (obsImage !== pat) begin miscompares++; $display("[TB] FAIL rst_latch: got %h expected %h", obsImage, pat); end
    tick();
    tbReq = 1'b1; tick(); tbReq = 1'b0; tick();
    vectors++; if (obsSpike !== 4'd1 || obsBusy !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre: spike=%0d busy=%0b expected 1/1", obsSpike, obsBusy); end
    tbRst = 1'b1; tick(); tick(); tbRst = 1'b0;
    vectors++; if (obsReady !== 1'b1 || obsBusy !== 1'b0 || obsNew !== 1'b0 || obsDone !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_flags: ready=%0b busy=%0b new=%0b done=%0b expected 1/0/0/0", obsReady, obsBusy, obsNew, obsDone); end
    vectors++; if (obsSpike !== 4'd0 || obsImage !== '0) begin miscompares++; $display("[TB] FAIL rst_mid_data: spike=%0d image=%h expected 0/0", obsSpike, obsImage); end
  endtask

  task automatic test_normal();
    img_t pat;
    int   d0;
    pat = {5'd3, 5'd0, 5'd7, 5'd1, 5'd9};
    d0 = doneA;
    tbImage = pat; tbValid = 1'b1;
    tick();
    tbValid = 1'b0;
    vectors++; if (obsNew !== 1'b1 || obsReady !== 1'b0 || obsBusy !== 1'b1) begin miscompares++; $display("[TB] FAIL norm_load: new=%0b ready=%0b busy=%0b expected 1/0/1", obsNew, obsReady, obsBusy); end
    vectors++; if (obsImage !== pat) begin miscompares++; $display("[TB] FAIL norm_image: got %h expected %h", obsImage, pat); end
    tick();
    vectors++; if (obsNew !== 1'b0) begin miscompares++; $display("[TB] FAIL norm_new_width: got %0b expected 0", obsNew); end
    for (int i = 0; i < 4; i++) spike(2);
    vectors++; if (obsSpike !== 4'd4) begin miscompares++; $display("[TB] FAIL norm_spikes: got %0d expected 4", obsSpike); end
    tbEncoded = 1'b1;
    tick();
    tbEncoded = 1'b0;
    vectors++; if (obsDone !== 1'b1 || obsImg !== 16'd0) begin miscompares++; $display("[TB] FAIL norm_done: done=%0b img=%0d expected 1/0", obsDone, obsImg); end
    tick();
    vectors++; if (obsDone !== 1'b0 || obsImg !== 16'd1 || (doneA - d0) != 1) begin miscompares++; $display("[TB] FAIL norm_after: done=%0b img=%0d pulses=%0d expected 0/1/1", obsDone, obsImg, doneA - d0); end
    repeat (15) tick();
    vectors++; if (obsReady !== 1'b0 || obsBusy !== 1'b1) begin miscompares++; $display("[TB] FAIL norm_rest_end: ready=%0b busy=%0b expected 0/1", obsReady, obsBusy); end
    tick();
    vectors++; if (obsReady !== 1'b1 || obsSpike !== 4'd4) begin miscompares++; $display("[TB] FAIL norm_idle: ready=%0b spike=%0d expected 1/4", obsReady, obsSpike); end
  endtask

  task automatic test_drain_hold();
    int   d0;
    logic early;
    d0 = doneA;
    early = 1'b0;
    tbImage = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}; tbValid = 1'b1;
    tick();
    tbValid = 1'b0;
    tick();
    tbReq = 1'b1;
    tick();
    tbEncoded = 1'b1;
    tick();
    tbEncoded = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (obsDone !== 1'b0 || obsReady !== 1'b0) early = 1'b1;
      tick();
    end
    tbAck = 1'b1; tick();
    if (obsDone !== 1'b0) early = 1'b1;
    tbReq = 1'b0; tick();
    if (obsDone !== 1'b0) early = 1'b1;
    tbAck = 1'b0; tick();
    vectors++; if (early !== 1'b0 || (doneA - d0) != 0) begin miscompares++; $display("[TB] FAIL drain_early: early=%0b pulses=%0d expected 0/0", early, doneA - d0); end
    vectors++; if (obsDone !== 1'b1 || obsReady !== 1'b0 || obsImg !== 16'd1) begin miscompares++; $display("[TB] FAIL drain_done: done=%0b ready=%0b img=%0d expected 1/0/1", obsDone, obsReady, obsImg); end
    tick();
    vectors++; if (obsImg !== 16'd2 || obsSpike !== 4'd1) begin miscompares++; $display("[TB] FAIL drain_count: img=%0d spike=%0d expected 2/1", obsImg, obsSpike); end
    repeat (16) tick();
    vectors++; if (obsReady !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_idle: ready=%0b expected 1", obsReady); end
  endtask

  task automatic test_abort();
    img_t p1, p2;
    int   d0;
    p1 = {5'd10, 5'd2, 5'd4, 5'd6, 5'd8};
    p2 = {5'd1, 5'd1, 5'd5, 5'd0, 5'd10};
    d0 = doneA;
    tbAbort = 1'b1;
    tick();
    vectors++; if (obsReady !== 1'b1 || obsBusy !== 1'b0 || obsImg !== 16'd2) begin miscompares++; $display("[TB] FAIL abort_idle: ready=%0b busy=%0b img=%0d expected 1/0/2", obsReady, obsBusy, obsImg); end
    tbImage = p1; tbValid = 1'b1;
    tick();
    tbValid = 1'b0; tbAbort = 1'b0;
    vectors++; if (obsNew !== 1'b1 || obsImage !== p1) begin miscompares++; $display("[TB] FAIL abort_idle_accept: new=%0b image=%h expected 1/%h", obsNew, obsImage, p1); end
    tick();
    spike(2);
    tbAbort = 1'b1;
    tick();
    tbAbort = 1'b0;
    vectors++; if (obsBusy !== 1'b0 || obsReady !== 1'b1 || (doneA - d0) != 0 || obsImg !== 16'd2) begin miscompares++; $display("[TB] FAIL abort_exit: busy=%0b ready=%0b pulses=%0d img=%0d expected 0/1/0/2", obsBusy, obsReady, doneA - d0, obsImg); end
    vectors++; if (obsSpike !== 4'd1 || obsImage !== p1) begin miscompares++; $display("[TB] FAIL abort_hold: spike=%0d image=%h expected 1/%h", obsSpike, obsImage, p1); end
    tbImage = p2; tbValid = 1'b1;
    tick();
    tbValid = 1'b0;
    vectors++; if (obsSpike !== 4'd0 || obsImage !== p2) begin miscompares++; $display("[TB] FAIL abort_restart: spike=%0d image=%h expected 0/%h", obsSpike, obsImage, p2); end
    tick();
    tbReq = 1'b1; tick(); tbReq = 1'b0; tick();
    tbEncoded = 1'b1; tick(); tbEncoded = 1'b0;
    tick();
    vectors++; if (obsImg !== 16'd3 || obsSpike !== 4'd1 || (doneA - d0) != 1) begin miscompares++; $display("[TB] FAIL abort_next: img=%0d spike=%0d pulses=%0d expected 3/1/1", obsImg, obsSpike, doneA - d0); end
    repeat (16) tick();
  endtask

  task automatic test_saturation();
    tbImage = {5'd9, 5'd9, 5'd9, 5'd9, 5'd9}; tbValid = 1'b1;
    tick();
    tbValid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tbReq = 1'b1; tick(); tbReq = 1'b0; tick();
    end
    vectors++; if (obsSpike !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_reach: got %0d expected 15", obsSpike); end
    for (int i = 0; i < 3; i++) begin
      tbReq = 1'b1; tick(); tbReq = 1'b0; tick();
    end
    vectors++; if (obsSpike !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_hold: got %0d expected 15", obsSpike); end
    tbEncoded = 1'b1; tick(); tbEncoded = 1'b0;
    tick();
    vectors++; if (obsImg !== 16'd4) begin miscompares++; $display("[TB] FAIL sat_img: got %0d expected 4", obsImg); end
  endtask

  task automatic test_watchdog();
    int d0;
    sel = 1'b1;
    d0 = doneB;
    tbImage = {5'd2, 5'd4, 5'd6, 5'd8, 5'd10}; tbValid = 1'b1;
    tick();
    tbValid = 1'b0;
    tick();
    repeat (7) tick();
    vectors++; if (obsTerr !== 1'b0 || obsBusy !== 1'b1) begin miscompares++; $display("[TB] FAIL wdog_early: terr=%0b busy=%0b expected 0/1", obsTerr, obsBusy); end
    tick();
    vectors++; if (obsTerr !== 1'b1 || obsReady !== 1'b1 || obsBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL wdog_fire: terr=%0b ready=%0b busy=%0b expected 1/1/0", obsTerr, obsReady, obsBusy); end
    vectors++; if (obsImg !== 16'd0 || (doneB - d0) != 0) begin miscompares++; $display("[TB] FAIL wdog_nodone: img=%0d pulses=%0d expected 0/0", obsImg, doneB - d0); end
    tbValid = 1'b1;
    tick();
    tbValid = 1'b0;
    tick();
    tbEncoded = 1'b1; tick(); tbEncoded = 1'b0;
    vectors++; if (obsDone !== 1'b1) begin miscompares++; $display("[TB] FAIL wdog_next_done: got %0b expected 1", obsDone); end
    tick();
    vectors++; if (obsImg !== 16'd1 || obsTerr !== 1'b1 || obsReady !== 1'b1) begin miscompares++; $display("[TB] FAIL wdog_sticky: img=%0d terr=%0b ready=%0b expected 1/1/1", obsImg, obsTerr, obsReady); end
  endtask

  task automatic test_back_to_back();
    int loadT[3];
    int nLoads;
    int d0;
    nLoads = 0;
    loadT = '{0, 0, 0};
    d0 = doneB;
    tbValid = 1'b1; tbEncoded = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (obsNew === 1'b1) begin
        if (nLoads < 3) loadT[nLoads] = t;
        nLoads++;
        if (nLoads == 3) tbValid = 1'b0;
      end
    end
    tbEncoded = 1'b0;
    vectors++; if (nLoads != 3) begin miscompares++; $display("[TB] FAIL b2b_loads: got %0d expected 3", nLoads); end
    vectors++; if (loadT[0] != 1 || loadT[1] != 5 || loadT[2] != 9) begin miscompares++; $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d expected 1,5,9", loadT[0], loadT[1], loadT[2]); end
    vectors++; if (obsImg !== 16'd4 || (doneB - d0) != 3 || obsReady !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_count: img=%0d pulses=%0d ready=%0b expected 4/3/1", obsImg, doneB - d0, obsReady); end
  endtask

  initial begin
    sel = 1'b0;
    tbImage = '0; tbValid = 1'b0; tbAbort = 1'b0;
    tbEncoded = 1'b0; tbReq = 1'b0; tbAck = 1'b0;
    tbRst = 1'b1;
    tick(); tick();
    tbRst = 1'b0;
    test_reset();
    test_normal();
    test_drain_hold();
    test_abort();
    test_saturation();
    test_watchdog();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/encoder_ctrl.md
# encoder_ctrl

Frame-level controller that sequences images into the encoder. It accepts one image at a time from the host over a valid/ready handshake and holds it stable on the encoder's IMAGE input. It then pulses NEW_IMAGE and monitors the AER output link, waiting for encoding to finish and the last spike handshake to complete. Finally it enforces a programmable rest gap before accepting the next image, with a watchdog timeout and per-image spike/image counters for the host.

## Interface
Parameters:
- IMAGE_SIZE, 5, pixels per image.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), index width; AER addresses are [IMAGE_SIZE_BITS:0].
- PIXEL_MAX_VALUE, 10, maximum pixel intensity.
- PIXEL_BITS, $clog2(PIXEL_MAX_VALUE), pixel width is [PIXEL_BITS:0].
- REST_CYCLES, 16, idle gap between images; 0 allowed.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in ENCODE; must be at least 1.

Ports:
- CLK  in  1  single clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- IN_IMAGE  in  [PIXEL_BITS:0] x [0:IMAGE_SIZE-1]  host image.
- IN_VALID  in  1  host image valid.
- IN_READY  out  1  controller can accept an image.
- ABORT  in  1  cancel the current image.
- IMAGE  out  [PIXEL_BITS:0] x [0:IMAGE_SIZE-1]  registered image to the encoder.
- NEW_IMAGE  out  1  one-cycle start pulse to the encoder.
- IMAGE_ENCODED  in  1  encoder reports sorting/encoding complete.
- AEROUT_REQ  in  1  monitored AER request (encoder to receiver).
- AEROUT_ACK  in  1  monitored AER acknowledge.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when an image completes normally.
- TIMEOUT_ERR  out  1  sticky watchdog flag.
- SPIKE_COUNT  out  [IMAGE_SIZE_BITS:0]  spikes emitted for the current or last image.
- IMG_COUNT  out  16  images completed normally.

## Operation
- **States:** IDLE, LOAD, ENCODE, DRAIN, REST.
- **IDLE:**
  - IN_READY=1.
  - When IN_VALID&IN_READY: latch IN_IMAGE into IMAGE, clear SPIKE_COUNT, go to LOAD.
- **LOAD:** lasts exactly one cycle with NEW_IMAGE=1. IMAGE_ENCODED is ignored. Go to ENCODE.
- **ENCODE:**
  - IMAGE_ENCODED=1 goes to DRAIN.
  - Otherwise the watchdog counter increments (cleared on entry). When it reaches TIMEOUT_CYCLES-1, set TIMEOUT_ERR and go to REST without DONE.
- **DRAIN:**
  - Wait until AEROUT_REQ=0 and AEROUT_ACK=0, i.e. the last 4-phase handshake has closed.
  - Then pulse DONE, IMG_COUNT+1 (wraps at 2^16), go to REST.
  - If the link is already idle on entry, exit on the first DRAIN cycle.
- **REST:** count REST_CYCLES cycles, then go to IDLE. With REST_CYCLES=0, REST lasts zero cycles: DRAIN/timeout go directly to IDLE.
- **Spike counting:**
  - A rising edge of AEROUT_REQ (REQ=1 this cycle, registered REQ=0) counts one spike, but only in LOAD, ENCODE or DRAIN.
  - SPIKE_COUNT saturates at all-ones.
  - The count holds after completion until the next accept.
- **ABORT:** sampled in any non-IDLE state. It forces IDLE on the next edge, with no DONE and no IMG_COUNT increment. IMAGE and SPIKE_COUNT hold. ABORT has no effect in IDLE.
- **Priority within a cycle:** RST > ABORT > timeout > IMAGE_ENCODED.
- **TIMEOUT_ERR:** cleared only by RST. It does not block further images.
- **IMAGE:** changes only on an accepted handshake, so it is stable to the encoder for the whole encode.

## Timing
- **Reset values:** state IDLE, IN_READY=1, NEW_IMAGE=0, BUSY=0, DONE=0, TIMEOUT_ERR=0, SPIKE_COUNT=0, IMG_COUNT=0, IMAGE all zeros. RST mid-operation returns to these values on the next edge.
- **Outputs:** NEW_IMAGE, DONE, BUSY and IN_READY are state-decoded registered outputs with no combinational path from inputs.
- **Accept to start:** handshake at edge N, then NEW_IMAGE high for cycle N+1, then ENCODE from N+2.
- **Encode exit:** IMAGE_ENCODED high at edge M in ENCODE, then DRAIN from M+1. With an idle link, DONE is high in cycle M+1 and REST from M+2.
- **Rest and reacceptance:** REST spans REST_CYCLES cycles. IN_READY is high again in the first cycle after REST.
- **Minimum image period:** 4 + REST_CYCLES cycles (IDLE, LOAD, ENCODE, DRAIN, REST). Back-to-back IN_VALID is accepted at this rate.
- **Timeout:** with IMAGE_ENCODED never asserted, TIMEOUT_ERR rises after exactly TIMEOUT_CYCLES cycles in ENCODE.

## Test plan
- **Reset:** RST for 2 cycles during ENCODE -> all outputs at reset values on the next cycle; IN_READY=1.
- **Normal image:** image {3,0,7,1,9}, encoder emits 4 spikes then IMAGE_ENCODED, ACK answered in 2 cycles -> NEW_IMAGE exactly 1 cycle, SPIKE_COUNT=4, one DONE pulse, IMG_COUNT=1, IN_READY back after REST_CYCLES=16.
- **Drain hold:** IMAGE_ENCODED while REQ=1 and ACK stalled 10 cycles -> DONE only after REQ=ACK=0; IN_READY stays 0 until then.
- **Watchdog:** TIMEOUT_CYCLES=8, IMAGE_ENCODED held 0 -> TIMEOUT_ERR=1 after 8 ENCODE cycles, no DONE, IMG_COUNT unchanged; the next image still completes and TIMEOUT_ERR stays 1.
- **Abort and ignored ABORT:** ABORT in ENCODE, then a new image -> BUSY=0 next cycle, no DONE; the next image's SPIKE_COUNT restarts from 0. ABORT in IDLE does nothing.
- **Stream with REST_CYCLES=0 and saturation:** IN_VALID held high for 3 images -> accepts spaced exactly 4 cycles, IMG_COUNT=3. Force 2^(IMAGE_SIZE_BITS+1)+2 REQ edges -> SPIKE_COUNT saturates at all-ones.
